// File: rtl/bbtron_defs_pkg.sv
// Shared definitions for the BBTRON core: FSM encodings used by both the
// control unit and the I/O controller, the datapath width default, the
// request-decode bundle and a sizing helper for the IN wait counter.
package bbtron_defs;

    // Default datapath width shared with the control unit
    localparam int BBTRON_DATA_W = 32;

    // I/O FSM encodings, kept as plain constants so the control unit can
    // compare against the same values
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Outcome of decoding one IDLE-cycle request
    typedef struct packed {
        logic err;
        logic out_go;
        logic in_go;
    } io_req_t;

    // Width of the IN wait counter: enough bits to hold TIMEOUT, never zero
    function automatic int timeout_cnt_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bbtron_edge_detect.sv
// Per-bit rising-edge detector for the debounced enter buttons. The
// previous level is registered every cycle regardless of what the
// consumer is doing, so a level already high never produces a late edge.
module bbtron_edge_detect #(
    parameter int W = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] level,
    output logic [W-1:0] rise
);

    logic [W-1:0] level_prev;

    // Remember last cycle's button levels
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_prev <= '0;
        end else begin
            level_prev <= level;
        end
    end

    // A rise is high now and low on the previous cycle
    always_comb begin
        rise = level & ~level_prev;
    end

endmodule

// File: rtl/bbtron_io_controller.sv
// I/O controller for the CPU's IN/OUT instructions. OUT writes one of
// N_OUT display registers in a single zero-latency cycle. IN stalls the
// core until the selected channel's enter button rises (or an optional
// timeout expires), then acknowledges with the extended switch value.
// Illegal requests are acknowledged immediately with io_err.
module bbtron_io_controller
    import bbtron_defs::*;
#(
    parameter int DATA_W  = BBTRON_DATA_W,
    parameter int SW_W    = 16,
    parameter int N_IN    = 2,
    parameter int N_OUT   = 3,
    parameter int CH_W    = 2,
    parameter int TIMEOUT = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_req,
    input  logic                    out_req,
    input  logic [CH_W-1:0]         chan,
    input  logic                    sign_ext,
    input  logic [DATA_W-1:0]       wr_data,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    stall,
    output logic                    ack,
    output logic                    timeout,
    output logic                    io_err,
    input  logic [N_IN-1:0]         enter_db,
    input  logic [N_IN*SW_W-1:0]    switches,
    output logic [N_OUT*DATA_W-1:0] disp_data,
    output logic [N_OUT-1:0]        disp_valid
);

    localparam int              CNT_W     = timeout_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CH_W:0]   IN_LIMIT  = (CH_W + 1)'(N_IN);
    localparam logic [CH_W:0]   OUT_LIMIT = (CH_W + 1)'(N_OUT);

    logic [1:0]              state;
    logic [1:0]              state_next;
    logic [CH_W-1:0]         chan_q;
    logic [CNT_W-1:0]        wait_cnt;
    logic                    timeout_flag;
    logic [N_IN-1:0]         rise;
    logic                    rise_sel;
    logic [SW_W-1:0]         sw_sel;
    logic [DATA_W-1:0]       ext_val;
    logic                    to_hit;
    logic [CH_W:0]           chan_wide;
    logic                    in_bad;
    logic                    out_bad;
    io_req_t                 req;
    logic [DATA_W-1:0]       rd_q;
    logic [N_OUT*DATA_W-1:0] disp_q;
    logic [N_OUT-1:0]        valid_q;

    bbtron_edge_detect #(
        .W (N_IN)
    ) u_edge_detect (
        .clock (clock),
        .reset (reset),
        .level (enter_db),
        .rise  (rise)
    );

    // Classify an IDLE-cycle request as an error, a legal OUT or a legal IN;
    // conflicting or out-of-range requests never change state
    always_comb begin
        req       = '0;
        chan_wide = {1'b0, chan};
        in_bad    = (chan_wide >= IN_LIMIT);
        out_bad   = (chan_wide >= OUT_LIMIT);
        if (state == ST_IDLE) begin
            if (in_req && out_req) begin
                req.err = 1'b1;
            end else if (in_req) begin
                if (in_bad) begin
                    req.err = 1'b1;
                end else begin
                    req.in_go = 1'b1;
                end
            end else if (out_req) begin
                if (out_bad) begin
                    req.err = 1'b1;
                end else begin
                    req.out_go = 1'b1;
                end
            end
        end
    end

    // Pick the latched channel's edge and switch bank, then extend the bank
    // to the datapath width (upper bits replicate the sign bit when asked)
    always_comb begin
        rise_sel = 1'b0;
        sw_sel   = '0;
        for (int c = 0; c < N_IN; c++) begin
            if (chan_q == CH_W'(c)) begin
                rise_sel = rise[c];
                sw_sel   = switches[c*SW_W +: SW_W];
            end
        end
        ext_val             = {DATA_W{sign_ext & sw_sel[SW_W-1]}};
        ext_val[SW_W-1:0]   = sw_sel;
        to_hit              = (TIMEOUT > 0) && (wait_cnt == CNT_LAST);
    end

    // FSM next state: IN waits for its press or timeout, DONE lasts one cycle
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req.in_go) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rise_sel || to_hit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register; reset abandons any IN in progress without ack
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the IN channel and run the saturating wait counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chan_q   <= '0;
            wait_cnt <= '0;
        end else if (req.in_go) begin
            chan_q   <= chan;
            wait_cnt <= '0;
        end else if ((state == ST_WAIT) && (wait_cnt != CNT_MAX)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Capture the IN result; a press on the final count beats the timeout
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_q         <= '0;
            timeout_flag <= 1'b0;
        end else if (req.in_go) begin
            timeout_flag <= 1'b0;
        end else if (state == ST_WAIT) begin
            if (rise_sel) begin
                rd_q         <= ext_val;
                timeout_flag <= 1'b0;
            end else if (to_hit) begin
                rd_q         <= '0;
                timeout_flag <= 1'b1;
            end
        end
    end

    // Display registers: a legal OUT writes its channel and marks it valid
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            disp_q  <= '0;
            valid_q <= '0;
        end else begin
            for (int c = 0; c < N_OUT; c++) begin
                if (req.out_go && (chan == CH_W'(c))) begin
                    disp_q[c*DATA_W +: DATA_W] <= wr_data;
                    valid_q[c]                 <= 1'b1;
                end
            end
        end
    end

    // Handshake outputs; held low while reset is asserted so the core sees
    // a clean idle controller even if a request is still being presented
    always_comb begin
        stall   = ~reset & (req.in_go | (state == ST_WAIT));
        ack     = ~reset & (req.err | req.out_go | (state == ST_DONE));
        io_err  = ~reset & req.err;
        timeout = ~reset & (state == ST_DONE) & timeout_flag;
    end

    assign rd_data    = rd_q;
    assign disp_data  = disp_q;
    assign disp_valid = valid_q;

endmodule

// File: tb/tb_bbtron_io_controller.sv
// Directed bench for bbtron_io_controller. Two instances share stimulus:
// dut0 waits forever on IN, dut8 gives up after eight wait cycles.
module tb_bbtron_io_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_req;
    logic        out_req;
    logic [1:0]  chan;
    logic        sign_ext;
    logic [31:0] wr_data;
    logic [1:0]  enter_db;
    logic [31:0] switches;

    logic [31:0] rd_data0,  rd_data8;
    logic        stall0,    stall8;
    logic        ack0,      ack8;
    logic        timeout0,  timeout8;
    logic        io_err0,   io_err8;
    logic [95:0] disp_data0, disp_data8;
    logic [2:0]  disp_valid0, disp_valid8;

    int check_count = 0;
    int pass_count  = 0;

    logic [1:0] s3_pattern [0:5];

    bbtron_io_controller #(
        .DATA_W(32), .SW_W(16), .N_IN(2), .N_OUT(3), .CH_W(2), .TIMEOUT(0)
    ) dut0 (
        .clock(clock), .reset(reset), .in_req(in_req), .out_req(out_req),
        .chan(chan), .sign_ext(sign_ext), .wr_data(wr_data),
        .rd_data(rd_data0), .stall(stall0), .ack(ack0), .timeout(timeout0),
        .io_err(io_err0), .enter_db(enter_db), .switches(switches),
        .disp_data(disp_data0), .disp_valid(disp_valid0)
    );

    bbtron_io_controller #(
        .DATA_W(32), .SW_W(16), .N_IN(2), .N_OUT(3), .CH_W(2), .TIMEOUT(8)
    ) dut8 (
        .clock(clock), .reset(reset), .in_req(in_req), .out_req(out_req),
        .chan(chan), .sign_ext(sign_ext), .wr_data(wr_data),
        .rd_data(rd_data8), .stall(stall8), .ack(ack8), .timeout(timeout8),
        .io_err(io_err8), .enter_db(enter_db), .switches(switches),
        .disp_data(disp_data8), .disp_valid(disp_valid8)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Present an IN and optionally press the channel's button at cycle
    // press_at (cycle 0 is the request cycle). Returns at the falling edge
    // of the ack cycle with the number of stalled cycles before it.
    task automatic apply_in(input bit use8, input logic [1:0] ch, input logic [15:0] sw,
                            input logic sext, input int press_at, input int max_cyc,
                            output int stalls, output bit got_ack);
        stalls  = 0;
        got_ack = 1'b0;
        chan     = ch;
        sign_ext = sext;
        switches[int'(ch)*16 +: 16] = sw;
        out_req  = 1'b0;
        in_req   = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            if (i == press_at) enter_db[ch] = 1'b1;
            @(negedge clock);
            if ((use8 ? ack8 : ack0) === 1'b1) begin
                got_ack = 1'b1;
                break;
            end
            if ((use8 ? stall8 : stall0) === 1'b1) stalls++;
            next_cycle();
        end
    endtask

    task automatic finish_in();
        next_cycle();
        in_req   = 1'b0;
        enter_db = 2'b00;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  stalls;
        bit  got;
        bit  ack_seen;
        bit  stall_all;

        s3_pattern[0] = 2'b01; s3_pattern[1] = 2'b01; s3_pattern[2] = 2'b11;
        s3_pattern[3] = 2'b11; s3_pattern[4] = 2'b00; s3_pattern[5] = 2'b01;

        reset = 1'b1; in_req = 1'b0; out_req = 1'b0; chan = 2'd0; sign_ext = 1'b0;
        wr_data = 32'h0; enter_db = 2'b00; switches = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        check_output("reset_rd_data", 64'(rd_data0), 64'h0);
        check_output("reset_disp_valid", 64'(disp_valid0), 64'h0);
        check_output("reset_ack", 64'(ack0), 64'h0);
        reset = 1'b0;
        next_cycle();

        // OUT to channel 2
        out_req = 1'b1; chan = 2'd2; wr_data = 32'hDEADBEEF;
        @(negedge clock);
        check_output("out_ack", 64'(ack0), 64'h1);
        check_output("out_stall", 64'(stall0), 64'h0);
        check_output("out_io_err", 64'(io_err0), 64'h0);
        next_cycle();
        out_req = 1'b0;
        @(negedge clock);
        check_output("out_disp2", 64'(disp_data0[95:64]), 64'hDEADBEEF);
        check_output("out_valid", 64'(disp_valid0), 64'h4);
        next_cycle();

        // IN channel 1, press five cycles later, sign- then zero-extended
        apply_in(1'b0, 2'd1, 16'h8001, 1'b1, 5, 20, stalls, got);
        check_output("in_sx_ack", 64'(got), 64'h1);
        check_output("in_sx_stalls", 64'(stalls), 64'd6);
        check_output("in_sx_stall_on_ack", 64'(stall0), 64'h0);
        check_output("in_sx_rd_data", 64'(rd_data0), 64'hFFFF8001);
        check_output("in_sx_timeout", 64'(timeout0), 64'h0);
        finish_in();
        next_cycle();
        apply_in(1'b0, 2'd1, 16'h8001, 1'b0, 5, 20, stalls, got);
        check_output("in_zx_ack", 64'(got), 64'h1);
        check_output("in_zx_stalls", 64'(stalls), 64'd6);
        check_output("in_zx_rd_data", 64'(rd_data0), 64'h00008001);
        finish_in();
        next_cycle();

        // Held button and other-channel rise must not complete the IN
        in_req = 1'b1; chan = 2'd0; sign_ext = 1'b0; switches[15:0] = 16'h1234;
        ack_seen = 1'b0; stall_all = 1'b1;
        for (int i = 0; i < 6; i++) begin
            enter_db = s3_pattern[i];
            @(negedge clock);
            ack_seen  = ack_seen | ack0;
            stall_all = stall_all & stall0;
            next_cycle();
        end
        @(negedge clock);
        check_output("held_no_early_ack", 64'(ack_seen), 64'h0);
        check_output("held_stalled", 64'(stall_all), 64'h1);
        check_output("held_ack", 64'(ack0), 64'h1);
        check_output("held_rd_data", 64'(rd_data0), 64'h00001234);
        finish_in();
        next_cycle();

        // TIMEOUT=8: press on the last count wins, then a pure timeout
        apply_in(1'b1, 2'd0, 16'hA5A5, 1'b1, 8, 30, stalls, got);
        check_output("to_race_ack", 64'(got), 64'h1);
        check_output("to_race_stalls", 64'(stalls), 64'd9);
        check_output("to_race_timeout", 64'(timeout8), 64'h0);
        check_output("to_race_rd_data", 64'(rd_data8), 64'hFFFFA5A5);
        finish_in();
        next_cycle();
        apply_in(1'b1, 2'd0, 16'h7777, 1'b0, -1, 30, stalls, got);
        check_output("to_ack", 64'(got), 64'h1);
        check_output("to_stalls", 64'(stalls), 64'd9);
        check_output("to_timeout", 64'(timeout8), 64'h1);
        check_output("to_io_err", 64'(io_err8), 64'h0);
        check_output("to_rd_data", 64'(rd_data8), 64'h0);
        check_output("no_to_still_waiting", 64'(stall0), 64'h1);
        finish_in();
        next_cycle();
        enter_db[0] = 1'b1;
        next_cycle();
        enter_db = 2'b00;
        @(negedge clock);
        check_output("no_to_late_ack", 64'(ack0), 64'h1);
        check_output("no_to_late_rd_data", 64'(rd_data0), 64'h00007777);
        check_output("no_to_timeout", 64'(timeout0), 64'h0);
        next_cycle();
        next_cycle();

        // Illegal requests
        in_req = 1'b1; out_req = 1'b1; chan = 2'd0; wr_data = 32'h11111111;
        @(negedge clock);
        check_output("both_ack", 64'(ack0), 64'h1);
        check_output("both_io_err", 64'(io_err0), 64'h1);
        check_output("both_stall", 64'(stall0), 64'h0);
        next_cycle();
        out_req = 1'b0; chan = 2'd3;
        @(negedge clock);
        check_output("in_ch3_ack", 64'(ack0), 64'h1);
        check_output("in_ch3_io_err", 64'(io_err0), 64'h1);
        check_output("in_ch3_stall", 64'(stall0), 64'h0);
        next_cycle();
        in_req = 1'b0; out_req = 1'b1; chan = 2'd3;
        @(negedge clock);
        check_output("out_ch3_io_err", 64'(io_err0), 64'h1);
        next_cycle();
        out_req = 1'b0;
        @(negedge clock);
        check_output("err_disp_hi", 64'(disp_data0[95:64]), 64'hDEADBEEF);
        check_output("err_disp_lo", disp_data0[63:0], 64'h0);
        check_output("err_disp_valid", 64'(disp_valid0), 64'h4);
        check_output("err_idle_stall", 64'(stall0), 64'h0);
        check_output("err_idle_ack", 64'(ack0), 64'h0);
        next_cycle();

        // Reset in the middle of WAIT
        in_req = 1'b1; chan = 2'd1; sign_ext = 1'b1; switches[31:16] = 16'h8001;
        enter_db = 2'b00;
        repeat (3) next_cycle();
        #1;
        reset = 1'b1;
        #1;
        check_output("rst_stall", 64'(stall0), 64'h0);
        check_output("rst_ack", 64'(ack0), 64'h0);
        check_output("rst_rd_data", 64'(rd_data0), 64'h0);
        check_output("rst_disp_data", 64'(disp_data0[95:64]), 64'h0);
        check_output("rst_disp_valid", 64'(disp_valid0), 64'h0);
        in_req = 1'b0;
        next_cycle();
        reset = 1'b0;
        next_cycle();
        apply_in(1'b0, 2'd1, 16'h8001, 1'b1, 5, 20, stalls, got);
        check_output("post_rst_ack", 64'(got), 64'h1);
        check_output("post_rst_stalls", 64'(stalls), 64'd6);
        check_output("post_rst_rd_data", 64'(rd_data0), 64'hFFFF8001);
        finish_in();
        next_cycle();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
